// File: rtl/ram_arbiter_if.sv
// Requester handshakes and RAM control/data pins around ram_arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface ram_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  req_a, req_b;
  logic                  we_a, we_b;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic [DATA_WIDTH-1:0] wdata_a, wdata_b;
  logic                  gnt_a, gnt_b;
  logic                  done_a, done_b;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
  logic                  ram_cs, ram_we, ram_oe;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, ram_dout,
    output gnt_a, gnt_b, done_a, done_b, rdata_a, rdata_b,
    output ram_cs, ram_we, ram_oe, ram_addr, ram_din
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, ram_dout,
    input  gnt_a, gnt_b, done_a, done_b, rdata_a, rdata_b,
    input  ram_cs, ram_we, ram_oe, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single-port synchronous RAM.
// Define RAM_ARB_FIXED_PRIO_EN to make port A win every tie instead of alternating.
module ram_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_e                state_q, state_d;
  logic                  owner_q;
  logic                  sel_a, sel_b, xfer;
  logic                  cs_d, we_d, oe_d;
  logic                  we_sel;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic                  finish;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic                  last_q;
`endif

  // Pick the winning requester; only acted upon while IDLE.
  always_comb begin
`ifdef RAM_ARB_FIXED_PRIO_EN
    sel_a = bus.req_a;
`else
    sel_a = bus.req_a && (!bus.req_b || (last_q == PORT_B));
`endif
    sel_b     = bus.req_b && !sel_a;
    xfer      = (state_q == IDLE) && (sel_a || sel_b);
    we_sel    = sel_a ? bus.we_a    : bus.we_b;
    addr_sel  = sel_a ? bus.addr_a  : bus.addr_b;
    wdata_sel = sel_a ? bus.wdata_a : bus.wdata_b;
    finish    = (state_q == WRITE) || (state_q == CAPTURE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    bus.gnt_a = 1'b0;
    bus.gnt_b = 1'b0;
    cs_d      = 1'b0;
    we_d      = 1'b0;
    oe_d      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.gnt_a = sel_a && !rst;
        bus.gnt_b = sel_b && !rst;
        if (xfer) state_d = we_sel ? WRITE : READ;
      end
      WRITE:   state_d = IDLE;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // RAM controls follow the next state so they are registered and glitch-free.
    case (state_d)
      WRITE: begin
        cs_d = 1'b1;
        we_d = 1'b1;
      end
      READ, CAPTURE: begin
        cs_d = 1'b1;
        oe_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Command register, RAM pins and per-port completion/read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= PORT_A;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_q       <= PORT_B;
`endif
      bus.ram_cs   <= 1'b0;
      bus.ram_we   <= 1'b0;
      bus.ram_oe   <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_din  <= '0;
      bus.done_a   <= 1'b0;
      bus.done_b   <= 1'b0;
      bus.rdata_a  <= '0;
      bus.rdata_b  <= '0;
    end else begin
      bus.ram_cs <= cs_d;
      bus.ram_we <= we_d;
      bus.ram_oe <= oe_d;
      if (xfer) begin
        owner_q      <= sel_b ? PORT_B : PORT_A;
`ifndef RAM_ARB_FIXED_PRIO_EN
        last_q       <= sel_b ? PORT_B : PORT_A;
`endif
        bus.ram_addr <= addr_sel;
        bus.ram_din  <= wdata_sel;
      end
      bus.done_a <= finish && (owner_q == PORT_A);
      bus.done_b <= finish && (owner_q == PORT_B);
      if ((state_q == CAPTURE) && (owner_q == PORT_A)) bus.rdata_a <= bus.ram_dout;
      if ((state_q == CAPTURE) && (owner_q == PORT_B)) bus.rdata_b <= bus.ram_dout;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: queued requesters, a RAM model and a
// transaction-level reference model that predicts grants, completions and RAM pins.
module tb_ram_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    gap;
  } txn_t;

  logic clk = 1'b0;
  logic rst;

  ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;

  // Synchronous RAM with registered read output.
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
      else            ram_q <= ram_mem[bus.ram_addr];
    end
  end
  assign bus.ram_dout = (bus.ram_cs && !bus.ram_we && bus.ram_oe) ? ram_q : '0;

  // Requester drivers: hold each request until its grant edge.
  txn_t qa[$];
  txn_t qb[$];
  logic act_a = 1'b0, act_b = 1'b0;
  logic xfer_a = 1'b0, xfer_b = 1'b0;

  function automatic txn_t mk(input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [3:0] gap);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.gap = gap;
    return t;
  endfunction

  initial begin
    txn_t t;
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;
    forever begin
      @(posedge clk); #1;
      if (xfer_a) act_a = 1'b0;
      if (!act_a && qa.size() > 0) begin
        t = qa[0];
        if (t.gap > 4'd0) begin
          t.gap = t.gap - 4'd1;
          qa[0] = t;
        end else begin
          t = qa.pop_front();
          bus.we_a = t.we; bus.addr_a = t.addr; bus.wdata_a = t.wdata;
          act_a = 1'b1;
        end
      end
      bus.req_a = act_a;
      if (xfer_b) act_b = 1'b0;
      if (!act_b && qb.size() > 0) begin
        t = qb[0];
        if (t.gap > 4'd0) begin
          t.gap = t.gap - 4'd1;
          qb[0] = t;
        end else begin
          t = qb.pop_front();
          bus.we_b = t.we; bus.addr_b = t.addr; bus.wdata_b = t.wdata;
          act_b = 1'b1;
        end
      end
      bus.req_b = act_b;
    end
  end

  // Reference model: one access in flight, fixed latencies, alternate on ties.
  int unsigned   cyc = 0;
  logic [DW-1:0] mmem [256];
  logic          pend = 1'b0, p_owner_b = 1'b0, p_read = 1'b0;
  int unsigned   p_due = 0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0, p_rdata = '0;
  logic          last_b = 1'b1;
  logic [DW-1:0] er_a = '0, er_b = '0;
  int unsigned   nd_a = 0, nd_b = 0;
  logic          glog[$];
  logic          m_done_a, m_done_b, m_ga, m_gb, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend = 1'b0; last_b = 1'b1; er_a = '0; er_b = '0;
        xfer_a = 1'b0; xfer_b = 1'b0;
      end else begin
        m_done_a = pend && (p_due == cyc) && !p_owner_b;
        m_done_b = pend && (p_due == cyc) && p_owner_b;
        if (m_done_a && p_read) er_a = p_rdata;
        if (m_done_b && p_read) er_b = p_rdata;
        if (pend && (p_due == cyc)) pend = 1'b0;
        if (bus.done_a) nd_a++;
        if (bus.done_b) nd_b++;
        checks++;
        if ({bus.done_a, bus.done_b} !== {m_done_a, m_done_b})
          $display("FAIL done cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, bus.done_a, bus.done_b, m_done_a, m_done_b);
        else passed++;
        checks++;
        if ({bus.rdata_a, bus.rdata_b} !== {er_a, er_b})
          $display("FAIL rdata cyc=%0d got a=%h b=%h want a=%h b=%h", cyc, bus.rdata_a, bus.rdata_b, er_a, er_b);
        else passed++;
        checks++;
        if ({bus.ram_cs, bus.ram_we, bus.ram_oe} !== {pend, pend && !p_read, pend && p_read})
          $display("FAIL ram_ctrl cyc=%0d got cs/we/oe=%b%b%b want=%b%b%b", cyc, bus.ram_cs, bus.ram_we, bus.ram_oe,
                   pend, pend && !p_read, pend && p_read);
        else passed++;
        checks++;
        if ((bus.ram_we & bus.ram_oe) !== 1'b0)
          $display("FAIL we_oe_overlap cyc=%0d got=%b want=0", cyc, bus.ram_we & bus.ram_oe);
        else passed++;
        if (pend) begin
          checks++;
          if (bus.ram_addr !== p_addr || (!p_read && bus.ram_din !== p_wdata))
            $display("FAIL ram_cmd cyc=%0d got addr=%h din=%h want addr=%h din=%h", cyc, bus.ram_addr, bus.ram_din, p_addr, p_wdata);
          else passed++;
        end
        m_ga = 1'b0;
        m_gb = 1'b0;
        if (!pend) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
          m_ga = bus.req_a;
`else
          m_ga = bus.req_a && (!bus.req_b || last_b);
`endif
          m_gb = bus.req_b && !m_ga;
        end
        checks++;
        if ({bus.gnt_a, bus.gnt_b} !== {m_ga, m_gb})
          $display("FAIL gnt cyc=%0d got a=%b b=%b want a=%b b=%b", cyc, bus.gnt_a, bus.gnt_b, m_ga, m_gb);
        else passed++;
        xfer_a = m_ga;
        xfer_b = m_gb;
        if (m_ga || m_gb) begin
          m_we      = m_ga ? bus.we_a : bus.we_b;
          m_addr    = m_ga ? bus.addr_a : bus.addr_b;
          m_wdata   = m_ga ? bus.wdata_a : bus.wdata_b;
          pend      = 1'b1;
          p_owner_b = m_gb;
          p_read    = !m_we;
          p_addr    = m_addr;
          p_wdata   = m_wdata;
          p_due     = cyc + (m_we ? 32'd2 : 32'd3);
          if (m_we) mmem[m_addr] = m_wdata;
          else      p_rdata = mmem[m_addr];
          last_b = m_gb;
          glog.push_back(m_gb);
        end
      end
    end
  end

  task automatic wait_xfer(input logic port_b, input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      ok = port_b ? (bus.req_b && bus.gnt_b) : (bus.req_a && bus.gnt_a);
    end
  endtask

  task automatic wait_done(input logic port_b, input int unsigned budget,
                           output int unsigned n, output bit ok);
    ok = 1'b0;
    n = 0;
    while (!ok && n < budget) begin
      @(negedge clk); #1;
      n++;
      ok = port_b ? bus.done_b : bus.done_a;
    end
  endtask

  task automatic wait_quiet(input int unsigned budget);
    int unsigned n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || act_a || act_b || pend) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= budget) $display("FAIL quiet_timeout got=busy want=idle after %0d cycles", n);
    else passed++;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    qa.push_back(mk(1'b1, 8'h80, 8'h33, 4'd0));
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.ram_cs, bus.ram_we, bus.ram_oe} !== 7'b0)
      $display("FAIL reset_ctrl got=%b want=0000000", {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b,
               bus.ram_cs, bus.ram_we, bus.ram_oe});
    else passed++;
    checks++;
    if ({bus.rdata_a, bus.rdata_b, bus.ram_addr, bus.ram_din} !== 32'h0)
      $display("FAIL reset_data got rdata_a=%h rdata_b=%h addr=%h din=%h want all 0", bus.rdata_a, bus.rdata_b,
               bus.ram_addr, bus.ram_din);
    else passed++;
    checks++;
    if (bus.req_a !== 1'b1 || bus.gnt_a !== 1'b0)
      $display("FAIL gnt_in_reset got req=%b gnt=%b want req=1 gnt=0", bus.req_a, bus.gnt_a);
    else passed++;
    @(posedge clk); #2;
    rst = 1'b0;
    wait_quiet(50);
  endtask

  task automatic test_write_read_a();
    bit ok;
    int unsigned n, nb0;
    nb0 = nd_b;
    qa.push_back(mk(1'b1, 8'h10, 8'h5A, 4'd0));
    wait_xfer(1'b0, 20, ok);
    wait_done(1'b0, 10, n, ok);
    checks++;
    if (!ok || n != 2) $display("FAIL wr_done_latency got=%0d want=2", n);
    else passed++;
    qa.push_back(mk(1'b0, 8'h10, 8'h00, 4'd0));
    wait_xfer(1'b0, 20, ok);
    wait_done(1'b0, 10, n, ok);
    checks++;
    if (!ok || n != 3) $display("FAIL rd_done_latency got=%0d want=3", n);
    else passed++;
    checks++;
    if (bus.rdata_a !== 8'h5A) $display("FAIL rd_data_a got=%h want=5a", bus.rdata_a);
    else passed++;
    checks++;
    if (nd_b != nb0) $display("FAIL done_b_spurious got=%0d want=0", nd_b - nb0);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_order, got_order;
    pulse_reset();
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mk(1'b1, 8'h01, 8'h11, 4'd0));
      qb.push_back(mk(1'b1, 8'h02, 8'h22, 4'd0));
    end
    wait_quiet(200);
    exp_order = '0;
    got_order = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      exp_order[i] = (i >= 4);
`else
      exp_order[i] = (i % 2 == 1);
`endif
      if (i < glog.size()) got_order[i] = glog[i];
    end
    checks++;
    if (glog.size() != 8) $display("FAIL grant_count got=%0d want=8", glog.size());
    else passed++;
    checks++;
    if (got_order !== exp_order) $display("FAIL grant_order got=%b want=%b (bit0 first, 1=B)", got_order, exp_order);
    else passed++;
  endtask

  task automatic test_reset_capture();
    bit ok;
    int unsigned n, nb0;
    qb.push_back(mk(1'b0, 8'h02, 8'h00, 4'd0));
    wait_xfer(1'b1, 20, ok);
    wait_done(1'b1, 10, n, ok);
    checks++;
    if (!ok || bus.rdata_b !== 8'h22) $display("FAIL rd_b_first got=%h want=22", bus.rdata_b);
    else passed++;
    qb.push_back(mk(1'b0, 8'h02, 8'h00, 4'd0));
    wait_xfer(1'b1, 20, ok);
    @(posedge clk);
    @(posedge clk); #2;
    checks++;
    if (!ok || {bus.ram_cs, bus.ram_we, bus.ram_oe} !== 3'b101)
      $display("FAIL capture_ctrl got=%b want=101", {bus.ram_cs, bus.ram_we, bus.ram_oe});
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.ram_cs, bus.done_b, bus.rdata_b} !== 10'h0)
      $display("FAIL reset_mid_capture got cs=%b done_b=%b rdata_b=%h want 0 0 00", bus.ram_cs, bus.done_b, bus.rdata_b);
    else passed++;
    nb0 = nd_b;
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (nd_b != nb0) $display("FAIL dropped_done got=%0d want=0", nd_b - nb0);
    else passed++;
    qb.push_back(mk(1'b0, 8'h02, 8'h00, 4'd0));
    wait_xfer(1'b1, 20, ok);
    wait_done(1'b1, 10, n, ok);
    checks++;
    if (!ok || n != 3 || bus.rdata_b !== 8'h22) $display("FAIL reissue_read got lat=%0d data=%h want lat=3 data=22", n, bus.rdata_b);
    else passed++;
  endtask

  task automatic test_top_range();
    bit ok;
    int unsigned n;
    qa.push_back(mk(1'b1, 8'hFF, 8'hFF, 4'd0));
    qa.push_back(mk(1'b0, 8'hFF, 8'h00, 4'd0));
    wait_xfer(1'b0, 20, ok);
    wait_xfer(1'b0, 20, ok);
    @(posedge clk); #1;
    checks++;
    if (!ok || bus.ram_addr !== 8'hFF || bus.ram_oe !== 1'b1)
      $display("FAIL top_addr_read got addr=%h oe=%b want ff 1", bus.ram_addr, bus.ram_oe);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (bus.ram_addr !== 8'hFF || bus.ram_oe !== 1'b1)
      $display("FAIL top_addr_capture got addr=%h oe=%b want ff 1", bus.ram_addr, bus.ram_oe);
    else passed++;
    wait_done(1'b0, 10, n, ok);
    checks++;
    if (!ok || bus.rdata_a !== 8'hFF) $display("FAIL top_rdata got=%h want=ff", bus.rdata_a);
    else passed++;
  endtask

  task automatic test_random();
    int unsigned na0, nb0;
    for (int i = 0; i < 16; i++) qa.push_back(mk(1'b1, 8'(i), 8'($urandom), 4'd0));
    wait_quiet(200);
    na0 = nd_a;
    nb0 = nd_b;
    for (int i = 0; i < 30; i++) begin
      qa.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom), 4'($urandom_range(0, 3))));
      qb.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom), 4'($urandom_range(0, 3))));
    end
    wait_quiet(2000);
    checks++;
    if ((nd_a - na0) != 30 || (nd_b - nb0) != 30)
      $display("FAIL random_done_count got a=%0d b=%0d want 30 30", nd_a - na0, nd_b - nb0);
    else passed++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_write_read_a();
    test_round_robin();
    test_reset_capture();
    test_top_range();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
